// File: rtl/load_unit_pkg.sv
// load_unit_pkg: load types, FSM states and the misalignment predicate shared by the load path
package load_unit_pkg;
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_t;

    // Byte loads never fault; undefined funct3 codes are treated as word loads.
    function automatic logic is_misaligned(input logic [2:0] l_sel, input logic [1:0] b_sel);
        case (l_sel)
            LB, LBU: return 1'b0;
            LH, LHU: return b_sel[0];
            default: return b_sel != 2'b00;
        endcase
    endfunction
endpackage

// File: rtl/load_unit_if.sv
// load_unit_if: data-memory read bus (mem_req out of the load unit, mem_rvalid/mem_rdata back)
interface load_unit_if;
    logic        mem_req;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (output mem_req, input mem_rvalid, mem_rdata);
    modport slave (input mem_req, output mem_rvalid, mem_rdata);
endinterface

// File: rtl/load_unit_align.sv
// load_align: extracts byte/half/word from a read word and sign- or zero-extends it
// Ports: l_sel (load type), b_sel (byte offset), rdata (memory word) -> result (32-bit load value)
module load_align
    import load_unit_pkg::*;
(
    input  logic [2:0]  l_sel,
    input  logic [1:0]  b_sel,
    input  logic [31:0] rdata,
    output logic [31:0] result
);
    logic [7:0]  b8;
    logic [15:0] h16;

    assign b8  = rdata[{b_sel, 3'b000} +: 8];
    assign h16 = rdata[{b_sel[1], 4'b0000} +: 16];

    always_comb begin
        result = rdata;
        case (l_sel)
            LB:      result = {{24{b8[7]}}, b8};
            LH:      result = {{16{h16[15]}}, h16};
            LBU:     result = {24'd0, b8};
            LHU:     result = {16'd0, h16};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/load_unit.sv
// load_unit: MEM-stage load path; issues reads, stalls while waiting, aligns/extends data, flags faults
// Ports: clk/reset; MemRead, l_sel, b_sel, rd_in, flush from the pipeline; mem (read bus master);
//        LoadData/load_valid/rd_out result, StallLoad hold, misaligned/timeout exception pulses
module load_unit
    import load_unit_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic [2:0]  l_sel,
    input  logic [1:0]  b_sel,
    input  logic [4:0]  rd_in,
    input  logic        flush,
    load_unit_if.master mem,
    output logic [31:0] LoadData,
    output logic        load_valid,
    output logic [4:0]  rd_out,
    output logic        StallLoad,
    output logic        misaligned,
    output logic        timeout
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]  l_sel_q;
    logic [1:0]  b_sel_q;
    logic [4:0]  rd_q;
    logic [31:0] data_q;
    logic [4:0]  rd_out_q;
    logic        valid_q;
    logic        mis_q;
    logic        to_q;
    logic [31:0] aligned;
    logic        req_ok;
    logic        accept;

    load_align u_align (
        .l_sel  (l_sel_q),
        .b_sel  (b_sel_q),
        .rdata  (mem.mem_rdata),
        .result (aligned)
    );

    assign req_ok        = state_q == IDLE && MemRead && !flush;
    assign accept        = req_ok && !is_misaligned(l_sel, b_sel);
    assign mem.mem_req   = accept;
    assign StallLoad     = accept || state_q != IDLE;
    assign LoadData      = data_q;
    assign load_valid    = valid_q;
    assign rd_out        = rd_out_q;
    assign misaligned    = mis_q;
    assign timeout       = to_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            l_sel_q  <= '0;
            b_sel_q  <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            rd_out_q <= '0;
            valid_q  <= 1'b0;
            mis_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        l_sel_q <= l_sel;
                        b_sel_q <= b_sel;
                        rd_q    <= rd_in;
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end else if (req_ok) begin
                        mis_q <= 1'b1;
                    end
                end
                WAIT: begin
                    // Data beats timeout and flush; timeout beats flush so the counter never passes LAST.
                    if (mem.mem_rvalid) begin
                        if (!flush) begin
                            data_q   <= aligned;
                            rd_out_q <= rd_q;
                            valid_q  <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else if (cnt_q == LAST) begin
                        to_q    <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= flush ? DRAIN : WAIT;
                    end
                end
                DRAIN: begin
                    if (mem.mem_rvalid) begin
                        state_q <= IDLE;
                    end else if (cnt_q == LAST) begin
                        to_q    <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Read-path counterpart of the store path; sits in the MEM stage between the pipeline and data memory.
- Issues a load request, waits a variable number of cycles for the response and stalls the pipeline meanwhile.
- Extracts the byte, half-word or word, zero- or sign-extends it, and returns it with the destination tag.
- Flags misaligned loads and detects response timeouts.

Parameters:
- MAX_WAIT, 15: maximum cycles spent in WAIT before declaring a timeout; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- MemRead  in  1  load request from MEM stage
- l_sel  in  3  load type (funct3): 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- b_sel  in  2  byte offset, ALUResult[1:0]
- rd_in  in  5  destination register tag
- flush  in  1  kill the current or pending load
- mem_req  out  1  read strobe to data memory
- mem_rvalid  in  1  read data valid from memory
- mem_rdata  in  32  read word from memory
- LoadData  out  32  aligned, extended load result
- load_valid  out  1  LoadData/rd_out valid, one-cycle pulse
- rd_out  out  5  tag of the returned load
- StallLoad  out  1  hold upstream stages
- misaligned  out  1  misaligned-load exception pulse
- timeout  out  1  response timeout pulse

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE, counter=0. LoadData, load_valid, rd_out, misaligned and timeout are 0. Captured l_sel, b_sel and rd are 0.
- Misalignment:
  - LH/LHU with b_sel[0]=1 is misaligned.
  - LW with b_sel!=00 is misaligned.
  - Byte loads are never misaligned.
  - Undefined l_sel codes (011, 110, 111) behave as LW and are not flagged.
- States: IDLE, WAIT, DRAIN.
- IDLE:
  - MemRead=1, flush=0, aligned:
    - mem_req=1 combinationally in this cycle.
    - Capture l_sel, b_sel and rd_in; clear counter; go to WAIT.
    - StallLoad=1 in this cycle.
  - MemRead=1, flush=0, misaligned:
    - No mem_req; stay in IDLE.
    - misaligned=1 in the next cycle for one cycle.
    - StallLoad=0.
  - MemRead=1 with flush=1: ignored.
  - mem_rvalid in IDLE: spurious, ignored.
- WAIT (StallLoad=1, mem_req=0):
  - mem_rvalid=1, flush=0:
    - Register the extracted data into LoadData and the captured rd into rd_out.
    - load_valid=1 next cycle; go to IDLE.
  - mem_rvalid=1 with flush=1: discard the data, no load_valid, go to IDLE.
  - flush=1, no rvalid: go to DRAIN; counter continues.
  - No rvalid, counter==MAX_WAIT-1: go to IDLE; timeout=1 next cycle. WAIT therefore lasts at most MAX_WAIT cycles.
  - Otherwise: counter+1.
  - rvalid in the final permitted cycle is accepted; data wins over timeout.
- DRAIN (StallLoad=1):
  - Waits for the orphaned response. mem_rvalid discards the data and returns to IDLE; no load_valid.
  - The same timeout rule applies and asserts timeout.
  - MemRead is not accepted until back in IDLE.
- Latency: request in cycle T, mem_rvalid at T+k (k≥1), load_valid at T+k+1.
  - The next load is accepted no earlier than T+k+1.
  - load_valid and the exception pulses last exactly one cycle.
- Extraction, from the captured b_sel:
  - byte = rdata[8*b_sel +: 8]
  - half = rdata[16*b_sel[1] +: 16]
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - LoadData holds its value between loads.
- Reset mid-operation: forces IDLE and clears the pulses. A late mem_rvalid then arrives in IDLE and is ignored.
- Counter width: $clog2(MAX_WAIT+1); it never wraps.

Decomposition:
- Shared package holds:
  - the load-type enum (LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101);
  - the state enum (IDLE, WAIT, DRAIN);
  - the misalignment predicate as a function.
- One sub-module, load_align: combinational extractor and sign/zero extender taking (l_sel, b_sel, rdata) and producing the 32-bit result. The FSM, counter and output registers stay in load_unit.

Test Plan:
- LB, b_sel=11, rd_in=5, mem_rdata=0x80FF_1234 with rvalid 1 cycle after the request -> LoadData=0xFFFF_FF80, rd_out=5, load_valid one cycle, StallLoad high for exactly 2 cycles.
- LHU, b_sel=10, rdata=0x8001_7FFF -> 0x0000_8001; repeat as LH -> 0xFFFF_8001; LBU, b_sel=00 -> 0x0000_00FF.
- LW, b_sel=01 -> no mem_req, misaligned pulse next cycle, StallLoad=0, no load_valid; LH, b_sel=11 -> misaligned as well.
- MAX_WAIT=4:
  - no rvalid -> 4 WAIT cycles, then timeout pulse, state IDLE;
  - rerun with rvalid in the 4th WAIT cycle -> data returned, no timeout.
- flush on 2nd WAIT cycle, rvalid 3 cycles later with 0xDEADBEEF -> no load_valid, StallLoad held through DRAIN; the following LW (rdata 0x1234_5678) returns 0x1234_5678.
- reset asserted in WAIT, then rvalid next cycle -> ignored, all outputs 0, next load behaves normally.
